// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream arbitration multiplexer.
package stream_mux_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  // Index of the set bit in a one-hot vector of up to 32 channels; 0 when empty.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational arbiter: fixed priority from channel 0, or round-robin from ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  arb_mode_e     mode,
  output logic [N-1:0]  gnt
);

  int   start;
  int   idx;
  logic found;

  // NOTE: every variable gets a default before the loop, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    start = (mode == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream mux with packet lock, selectable arbitration
// and a registered output stage.
module stream_arb_mux
  import stream_mux_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int WIDTH   = 8,
  localparam int CH_BITS = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  arb_mode_e             mode,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [CH_BITS-1:0]    out_ch,
  input  logic                  out_ready
);

  lock_state_e          state_q, state_d;
  logic [CH_BITS-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [CH_BITS-1:0]   out_ch_q, out_ch_d;

  logic [N_CH-1:0]      arb_gnt;
  logic [N_CH-1:0]      gnt;
  logic [CH_BITS-1:0]   sel;
  logic                 ld;
  logic                 accept;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req  (in_valid),
    .ptr  (rr_ptr_q),
    .mode (mode),
    .gnt  (arb_gnt)
  );

  // A locked packet owns the output even while its producer idles.
  assign gnt      = (state_q == LOCKED) ? (N_CH'(1) << lock_ch_q) : arb_gnt;
  assign ld       = !out_valid_q || out_ready;
  assign in_ready = (rst || !ld) ? '0 : gnt;
  assign accept   = |(in_valid & in_ready);
  assign sel      = CH_BITS'(onehot_to_idx(32'(gnt)));

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (ld) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = in_data[int'(sel)*WIDTH +: WIDTH];
        out_last_d = in_last[sel];
        out_ch_d   = sel;
        if (in_last[sel]) begin
          state_d  = UNLOCKED;
          rr_ptr_d = (sel == CH_BITS'(N_CH - 1)) ? '0 : CH_BITS'(int'(sel) + 1);
        end else begin
          state_d   = LOCKED;
          lock_ch_d = sel;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scenario bench for stream_arb_mux: expected beats are queued as stimulus is
// driven and compared when the consumer takes them.
module tb_stream_arb_mux;
  import stream_mux_pkg::*;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [1:0]       ch;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  arb_mode_e             mode = ARB_FIXED;
  logic [N_CH-1:0]       in_valid = '0;
  logic [N_CH*WIDTH-1:0] in_data = '0;
  logic [N_CH-1:0]       in_last = '0;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [1:0]            out_ch;
  logic                  out_ready = 1'b1;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  stream_arb_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic set_ch(input int ch, input logic v, input logic [WIDTH-1:0] d, input logic l);
    in_valid[ch]            = v;
    in_data[ch*WIDTH +: 8]  = d;
    in_last[ch]             = l;
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] d, input logic l);
    beat_t b;
    b.ch   = 2'(ch);
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Consumes the presented beat against the scoreboard, then advances one cycle.
  task automatic step();
    beat_t e;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ch=%0d data=%h last=%b, required none", out_ch, out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_data, out_last} !== e) begin
          errors++;
          $display("FAIL sb_beat: got ch=%0d data=%h last=%b, required ch=%0d data=%h last=%b",
                   out_ch, out_data, out_last, e.ch, e.data, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid = '0;
    #1; step();
    #1; step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_last, out_ch} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b ch=%0d, required all 0",
               out_valid, out_data, out_last, out_ch);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
    end
    exp_q.delete();
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    mode = ARB_FIXED;
    for (int k = 0; k < 6; k++) begin
      in_valid = '0;
      set_ch(1, 1'b1, 8'h10 + 8'(k), 1'b1);
      set_ch(3, 1'b1, 8'h30 + 8'(k), 1'b1);
      push(1, 8'h10 + 8'(k), 1'b1);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        errors++;
        $display("FAIL fixed_ready[%0d]: got %b, required 0010", k, in_ready);
      end
      step();
    end
    drain("fixed");
  endtask

  task automatic test_rr_rotate();
    mode = ARB_RR;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < N_CH; c++) set_ch(c, 1'b1, 8'(c * 16 + k), 1'b1);
      push(k % 4, 8'((k % 4) * 16 + k), 1'b1);
      #1;
      checks++;
      if (in_ready !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b, required %b", k, in_ready, 4'(1 << (k % 4)));
      end
      step();
    end
    drain("rr");
  endtask

  task automatic test_packet_lock();
    mode     = ARB_RR;
    in_valid = '0;
    set_ch(1, 1'b1, 8'h11, 1'b1);
    push(1, 8'h11, 1'b1);
    #1; step();
    in_valid = '0;
    set_ch(0, 1'b1, 8'h01, 1'b1);
    set_ch(2, 1'b1, 8'h20, 1'b0);
    push(2, 8'h20, 1'b0);
    #1; step();
    set_ch(2, 1'b1, 8'h21, 1'b0);
    push(2, 8'h21, 1'b0);
    #1; step();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    for (int g = 0; g < 2; g++) begin
      #1;
      checks++;
      if ((in_ready & 4'b1011) !== 4'b0000) begin
        errors++;
        $display("FAIL lock_holdoff[%0d]: got in_ready=%b, required no ready outside ch2", g, in_ready);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lock_drain_valid: got %b, required 0", out_valid);
    end
    set_ch(2, 1'b1, 8'h22, 1'b1);
    push(2, 8'h22, 1'b1);
    #1; step();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    push(0, 8'h01, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL lock_release_ready: got %b, required 0001", in_ready);
    end
    step();
    drain("lock");
  endtask

  task automatic test_backpressure();
    mode     = ARB_FIXED;
    in_valid = '0;
    set_ch(3, 1'b1, 8'h3A, 1'b1);
    push(3, 8'h3A, 1'b1);
    #1; step();
    out_ready = 1'b0;
    set_ch(3, 1'b1, 8'h3B, 1'b1);
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if ({out_valid, out_data, out_ch, in_ready} !== {1'b1, 8'h3A, 2'd3, 4'b0000}) begin
        errors++;
        $display("FAIL stall[%0d]: got valid=%b data=%h ch=%0d ready=%b, required 1 3a 3 0000",
                 s, out_valid, out_data, out_ch, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    push(3, 8'h3B, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL stall_resume_ready: got %b, required 1000", in_ready);
    end
    step();
    drain("stall");
  endtask

  task automatic test_reset_mid_packet();
    mode     = ARB_RR;
    in_valid = '0;
    set_ch(1, 1'b1, 8'h51, 1'b0);
    push(1, 8'h51, 1'b0);
    #1; step();
    set_ch(1, 1'b1, 8'h52, 1'b0);
    test_reset();
    for (int c = 0; c < N_CH; c++) set_ch(c, 1'b1, 8'h60 + 8'(c), 1'b1);
    push(0, 8'h60, 1'b1);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b, required 0001", in_ready);
    end
    step();
    push(1, 8'h61, 1'b1);
    #1; step();
    drain("rst_mid");
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp_rdy [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
    mode     = ARB_FIXED;
    in_valid = '0;
    set_ch(2, 1'b1, 8'h70, 1'b0);
    push(2, 8'h70, 1'b0);
    #1;
    checks++;
    if (in_ready !== exp_rdy[0]) begin
      errors++;
      $display("FAIL mode_ready[0]: got %b, required %b", in_ready, exp_rdy[0]);
    end
    step();
    mode = ARB_RR;
    for (int k = 1; k < 4; k++) begin
      for (int c = 0; c < N_CH; c++) set_ch(c, 1'b1, 8'h80 + 8'(c * 4 + k), 1'b1);
      if (k < 3) begin
        set_ch(2, 1'b1, 8'h70 + 8'(k), k == 2);
        push(2, 8'h70 + 8'(k), k == 2);
      end else begin
        push(3, 8'h80 + 8'(12 + k), 1'b1);
      end
      #1;
      checks++;
      if (in_ready !== exp_rdy[k]) begin
        errors++;
        $display("FAIL mode_ready[%0d]: got %b, required %b", k, in_ready, exp_rdy[k]);
      end
      step();
    end
    drain("mode");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_reset();
    test_rr_rotate();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
